// File: rtl/led_frame_ctrl_pkg.sv
// Shared encodings and sizing for the LED frame controller and its PWM/ramp helper.
package led_frame_ctrl_pkg;

   localparam int ROWS        = 6;
   localparam int PWM_STEPS   = 8;
   localparam int RAMP_FRAMES = 16;
   localparam int SWEEP_DIV   = 4;
   localparam int LED_COUNT   = 75;
   localparam int NUM_IDX     = 0;
   localparam int CAPS_IDX    = 27;
   localparam int SCRL_IDX    = 13;

   localparam logic [2:0] PHASE_LAST     = 3'(ROWS - 1);
   localparam logic [3:0] LEVEL_MAX      = 4'(PWM_STEPS);
   localparam logic [2:0] PWM_LAST       = 3'(PWM_STEPS - 1);
   localparam logic [3:0] RAMP_LAST      = 4'(RAMP_FRAMES - 1);
   localparam logic [1:0] SWEEP_DIV_LAST = 2'(SWEEP_DIV - 1);
   localparam logic [6:0] SWEEP_POS_LAST = 7'(LED_COUNT - 1);

   typedef logic [LED_COUNT-1:0] led_t;

   typedef enum logic [1:0] {
      MODE_OFF      = 2'd0,
      MODE_STATIC   = 2'd1,
      MODE_REACTIVE = 2'd2,
      MODE_SWEEP    = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_SUSPEND = 2'd1,
      ST_RAMP    = 2'd2
   } state_e;

   function automatic logic [3:0] sat_level(input logic [3:0] b);
      return (b > LEVEL_MAX) ? LEVEL_MAX : b;
   endfunction

endpackage

// File: rtl/led_frame_ctrl_pwm_ramp.sv
// Per-frame brightness PWM with suspend and fade-in sequencing; drives the scan enable.
//  state      | meaning
//  ST_RUN     | level follows saturated brightness each frame
//  ST_SUSPEND | host asleep: drive off, level held at 0
//  ST_RAMP    | fade-in: level +1 every RAMP_FRAMES frames up to target
module led_pwm_ramp
   import led_frame_ctrl_pkg::*;
(
   input  logic       clk_scan,
   input  logic       reset,
   input  logic       frame_tick_i,
   input  logic [3:0] brightness_i,
   input  logic       suspend_i,
   output logic       enabled_o,
   output logic       suspended_o
);

   state_e     state_q, state_d;
   logic [3:0] level_q, level_d;
   logic [2:0] pwm_q, pwm_d;
   logic [3:0] ramp_q, ramp_d;
   logic       enabled_q, enabled_d;
   logic [3:0] target;

   always_comb begin
      state_d = state_q;
      level_d = level_q;
      pwm_d   = pwm_q;
      ramp_d  = ramp_q;
      target  = sat_level(brightness_i);

      if (frame_tick_i) begin
         pwm_d = (pwm_q == PWM_LAST) ? 3'd0 : pwm_q + 3'd1;
      end

      case (state_q)
         ST_RUN: begin
            if (suspend_i) begin
               state_d = ST_SUSPEND;
               level_d = 4'd0;
            end else if (frame_tick_i) begin
               level_d = target;
            end
         end
         ST_SUSPEND: begin
            level_d = 4'd0;
            if (!suspend_i) begin
               state_d = ST_RAMP;
               ramp_d  = RAMP_LAST;
            end
         end
         ST_RAMP: begin
            if (suspend_i) begin
               state_d = ST_SUSPEND;
               level_d = 4'd0;
            end else if (frame_tick_i) begin
               if (target <= level_q) begin
                  level_d = target;
                  state_d = ST_RUN;
               end else if (ramp_q == 4'd0) begin
                  level_d = level_q + 4'd1;
                  ramp_d  = RAMP_LAST;
               end else begin
                  ramp_d = ramp_q - 4'd1;
               end
            end
         end
         default: state_d = ST_RAMP;
      endcase

      // Built from next-state values so the enable lines up with the state it reflects.
      enabled_d = (state_d != ST_SUSPEND) && ({1'b0, pwm_d} < level_d);
   end

   always_ff @(posedge clk_scan or posedge reset) begin
      if (reset) begin
         state_q   <= ST_RAMP;
         level_q   <= 4'd0;
         pwm_q     <= 3'd0;
         ramp_q    <= RAMP_LAST;
         enabled_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         level_q   <= level_d;
         pwm_q     <= pwm_d;
         ramp_q    <= ramp_d;
         enabled_q <= enabled_d;
      end
   end

   assign enabled_o   = enabled_q;
   assign suspended_o = (state_q == ST_SUSPEND);

endmodule

// File: rtl/led_frame_ctrl.sv
// Frame-level controller for the 6-row LED scan engine: mode handshake, sweep,
// lock overlay and tear-free frame composition; brightness handled by led_pwm_ramp.
module led_frame_ctrl
   import led_frame_ctrl_pkg::*;
(
   input  logic                 clk_scan,
   input  logic                 reset,
   input  logic [LED_COUNT-1:0] key_state_i,
   input  logic [2:0]           lock_leds_i,
   input  logic [3:0]           brightness_i,
   input  logic                 suspend_i,
   input  logic                 mode_req_i,
   input  logic [1:0]           mode_in_i,
   output logic                 mode_ack_o,
   output logic [LED_COUNT-1:0] led_matrix_o,
   output logic                 enabled_o
);

   logic [2:0] phase_q, phase_d;
   mode_e      mode_q, mode_d;
   logic [6:0] sweep_pos_q, sweep_pos_d;
   logic [1:0] sweep_div_q, sweep_div_d;
   led_t       led_q, led_d;
   led_t       lit;
   logic       frame_tick;
   logic       mode_apply;
   logic       suspended;
   logic       freeze;

   assign frame_tick = (phase_q == PHASE_LAST);
   assign mode_apply = frame_tick && mode_req_i;
   assign freeze     = suspend_i || suspended;

   always_comb begin
      phase_d     = frame_tick ? 3'd0 : phase_q + 3'd1;
      mode_d      = mode_q;
      sweep_pos_d = sweep_pos_q;
      sweep_div_d = sweep_div_q;
      led_d       = led_q;

      if (mode_apply) begin
         mode_d = mode_e'(mode_in_i);
      end

      if (frame_tick && (mode_d == MODE_SWEEP)) begin
         if (mode_q != MODE_SWEEP) begin
            sweep_pos_d = 7'd0;
            sweep_div_d = 2'd0;
         end else if (sweep_div_q == SWEEP_DIV_LAST) begin
            sweep_div_d = 2'd0;
            sweep_pos_d = (sweep_pos_q == SWEEP_POS_LAST) ? 7'd0 : sweep_pos_q + 7'd1;
         end else begin
            sweep_div_d = sweep_div_q + 2'd1;
         end
      end

      // Compose with the mode being applied this tick so a new mode shows next frame.
      case (mode_d)
         MODE_OFF:      lit = '0;
         MODE_STATIC:   lit = '1;
         MODE_REACTIVE: lit = key_state_i;
         MODE_SWEEP:    lit = led_t'(1) << sweep_pos_d;
         default:       lit = '0;
      endcase
      lit[NUM_IDX]  = lit[NUM_IDX]  | lock_leds_i[0];
      lit[CAPS_IDX] = lit[CAPS_IDX] | lock_leds_i[1];
      lit[SCRL_IDX] = lit[SCRL_IDX] | lock_leds_i[2];

      if (frame_tick && !freeze) begin
         led_d = ~lit;
      end
   end

   always_ff @(posedge clk_scan or posedge reset) begin
      if (reset) begin
         phase_q     <= 3'd0;
         mode_q      <= MODE_STATIC;
         sweep_pos_q <= 7'd0;
         sweep_div_q <= 2'd0;
         led_q       <= '1;
      end else begin
         phase_q     <= phase_d;
         mode_q      <= mode_d;
         sweep_pos_q <= sweep_pos_d;
         sweep_div_q <= sweep_div_d;
         led_q       <= led_d;
      end
   end

   led_pwm_ramp u_pwm_ramp (
      .clk_scan     (clk_scan),
      .reset        (reset),
      .frame_tick_i (frame_tick),
      .brightness_i (brightness_i),
      .suspend_i    (suspend_i),
      .enabled_o    (enabled_o),
      .suspended_o  (suspended)
   );

   assign mode_ack_o   = mode_apply;
   assign led_matrix_o = led_q;

endmodule
